// File: rtl/apb_master_exe_ctrl_w47.sv
// APB master that sequences one W47 execution-unit command per request.
// Macro APB_EXE_CTRL_STATUS_READ_EN adds the trailing status readback step.
module apb_master_exe_ctrl_w47 #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  i_PCLK,
   input  logic                  i_PRESET,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic [DATA_WIDTH-1:0] i_cmd_oper,
   input  logic [DATA_WIDTH-1:0] i_cmd_argA,
   input  logic [DATA_WIDTH-1:0] i_cmd_argB,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_result,
   output logic [3:0]            o_rsp_status,
   output logic [1:0]            o_rsp_err,
   output logic [ADDR_WIDTH-1:0] o_PADDR,
   output logic                  o_PSEL,
   output logic                  o_PENABLE,
   output logic                  o_PWRITE,
   output logic [DATA_WIDTH-1:0] o_PWDATA,
   input  logic                  i_PREADY,
   input  logic [DATA_WIDTH-1:0] i_PRDATA,
   input  logic                  i_PSLVERR
);

   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

`ifdef APB_EXE_CTRL_STATUS_READ_EN
   localparam logic [2:0] LAST_STEP = 3'd4;
`else
   localparam logic [2:0] LAST_STEP = 3'd3;
`endif

   logic [1:0]            state_q, state_d;
   logic [2:0]            step_q, step_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic [DATA_WIDTH-1:0] oper_q, oper_d;
   logic [DATA_WIDTH-1:0] arga_q, arga_d;
   logic [DATA_WIDTH-1:0] argb_q, argb_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic [1:0]            err_q, err_d;
`ifdef APB_EXE_CTRL_STATUS_READ_EN
   logic [3:0]            status_q, status_d;
`endif

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      wait_d   = wait_q;
      oper_d   = oper_q;
      arga_d   = arga_q;
      argb_d   = argb_q;
      result_d = result_q;
      err_d    = err_q;
`ifdef APB_EXE_CTRL_STATUS_READ_EN
      status_d = status_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (i_cmd_valid) begin
               oper_d   = i_cmd_oper;
               arga_d   = i_cmd_argA;
               argb_d   = i_cmd_argB;
               result_d = '0;
               err_d    = 2'b00;
               step_d   = 3'd0;
               wait_d   = '0;
`ifdef APB_EXE_CTRL_STATUS_READ_EN
               status_d = '0;
`endif
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            wait_d  = '0;
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (i_PREADY) begin
               if (step_q == 3'd3) result_d = i_PRDATA;
`ifdef APB_EXE_CTRL_STATUS_READ_EN
               if (step_q == 3'd4) status_d = i_PRDATA[3:0];
`endif
               // A slave error abandons the rest of the sequence.
               if (i_PSLVERR) begin
                  err_d   = 2'b01;
                  state_d = S_RESP;
               end else if (step_q == LAST_STEP) begin
                  state_d = S_RESP;
               end else begin
                  step_d  = step_q + 3'd1;
                  state_d = S_SETUP;
               end
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 2'b10;
               state_d = S_RESP;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_RESP: begin
            if (i_rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_PCLK) begin
      if (i_PRESET) begin
         state_q  <= S_IDLE;
         step_q   <= '0;
         wait_q   <= '0;
         oper_q   <= '0;
         arga_q   <= '0;
         argb_q   <= '0;
         result_q <= '0;
         err_q    <= '0;
`ifdef APB_EXE_CTRL_STATUS_READ_EN
         status_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         wait_q   <= wait_d;
         oper_q   <= oper_d;
         arga_q   <= arga_d;
         argb_q   <= argb_d;
         result_q <= result_d;
         err_q    <= err_d;
`ifdef APB_EXE_CTRL_STATUS_READ_EN
         status_q <= status_d;
`endif
      end
   end

   logic                  busy;
   logic                  is_wr;
   logic [1:0]            addr_sel;
   logic [DATA_WIDTH-1:0] wdata;

   assign busy  = (state_q == S_SETUP) || (state_q == S_ACCESS);
   assign is_wr = (step_q < 3'd3);

   // Steps 3/4 read back the result/status registers at addresses 0/1.
   always_comb begin
      addr_sel = 2'd0;
      wdata    = '0;
      unique case (step_q)
         3'd0: wdata = oper_q;
         3'd1: begin
            addr_sel = 2'd1;
            wdata    = arga_q;
         end
         3'd2: begin
            addr_sel = 2'd2;
            wdata    = argb_q;
         end
         3'd4: addr_sel = 2'd1;
         default: addr_sel = 2'd0;
      endcase
   end

   assign o_cmd_ready  = (state_q == S_IDLE);
   assign o_rsp_valid  = (state_q == S_RESP);
   assign o_rsp_result = result_q;
   assign o_rsp_err    = err_q;
`ifdef APB_EXE_CTRL_STATUS_READ_EN
   assign o_rsp_status = status_q;
`else
   assign o_rsp_status = 4'd0;
`endif
   assign o_PSEL    = busy;
   assign o_PENABLE = (state_q == S_ACCESS);
   assign o_PWRITE  = busy && is_wr;
   assign o_PADDR   = busy ? ADDR_WIDTH'(addr_sel) : '0;
   assign o_PWDATA  = (busy && is_wr) ? wdata : '0;

endmodule

// File: tb/tb_apb_master_exe_ctrl_w47.sv
// Bench for apb_master_exe_ctrl_w47: APB slave model, monitor and
// transaction-level reference for sequence, latency and response.
module tb_apb_master_exe_ctrl_w47;

   localparam int TO = 16;
`ifdef APB_EXE_CTRL_STATUS_READ_EN
   localparam int NSTEPS = 5;
`else
   localparam int NSTEPS = 4;
`endif

   logic        clk = 1'b0;
   logic        i_PRESET;
   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic [7:0]  i_cmd_oper, i_cmd_argA, i_cmd_argB;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [7:0]  o_rsp_result;
   logic [3:0]  o_rsp_status;
   logic [1:0]  o_rsp_err;
   logic [15:0] o_PADDR;
   logic        o_PSEL, o_PENABLE, o_PWRITE;
   logic [7:0]  o_PWDATA;
   logic        i_PREADY;
   logic [7:0]  i_PRDATA;
   logic        i_PSLVERR;

   always #5 clk = ~clk;

   apb_master_exe_ctrl_w47 dut (
      .i_PCLK       (clk),
      .i_PRESET     (i_PRESET),
      .i_cmd_valid  (i_cmd_valid),
      .o_cmd_ready  (o_cmd_ready),
      .i_cmd_oper   (i_cmd_oper),
      .i_cmd_argA   (i_cmd_argA),
      .i_cmd_argB   (i_cmd_argB),
      .o_rsp_valid  (o_rsp_valid),
      .i_rsp_ready  (i_rsp_ready),
      .o_rsp_result (o_rsp_result),
      .o_rsp_status (o_rsp_status),
      .o_rsp_err    (o_rsp_err),
      .o_PADDR      (o_PADDR),
      .o_PSEL       (o_PSEL),
      .o_PENABLE    (o_PENABLE),
      .o_PWRITE     (o_PWRITE),
      .o_PWDATA     (o_PWDATA),
      .i_PREADY     (i_PREADY),
      .i_PRDATA     (i_PRDATA),
      .i_PSLVERR    (i_PSLVERR)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // slave configuration, written by the stimulus process only
   int         cfg_lat = 1;
   int         cfg_err = -1;
   int         cfg_hang = -1;
   int         cfg_base = 0;
   logic [7:0] mem0 = 8'h00;
   logic [7:0] mem1 = 8'h00;

   // monitor / slave state, written by the monitor process only
   logic [24:0] xlog[$];
   logic [24:0] su = '0;
   bit          prev_setup = 0;
   bit          prev_pend = 0;
   int          acc_cnt = 0;
   int          last_acc = 0;
   int          prot_errs = 0;

   always @(negedge clk) begin
      int   step;
      logic rdy;
      step = xlog.size() - cfg_base;
      if (o_PENABLE === 1'b1 && o_PSEL !== 1'b1) prot_errs++;
      if (prev_setup && !(o_PSEL && o_PENABLE)) prot_errs++;
      if (o_PSEL === 1'b1 && o_PENABLE === 1'b1) begin
         if (!(prev_setup || prev_pend)) prot_errs++;
         if ({o_PWRITE, o_PADDR, o_PWDATA} !== su) prot_errs++;
         acc_cnt++;
         last_acc = acc_cnt;
         rdy = (step != cfg_hang) && (acc_cnt > cfg_lat);
         i_PREADY  = rdy;
         i_PSLVERR = rdy && (step == cfg_err);
         i_PRDATA  = (o_PADDR == 16'd0) ? mem0 : mem1;
         if (rdy) xlog.push_back(su);
         prev_pend = !rdy;
      end else begin
         acc_cnt   = 0;
         i_PREADY  = 1'($urandom);
         i_PSLVERR = 1'($urandom);
         i_PRDATA  = 8'($urandom);
         prev_pend = 0;
         if (o_PSEL === 1'b1) su = {o_PWRITE, o_PADDR, o_PWDATA};
      end
      prev_setup = (o_PSEL === 1'b1) && (o_PENABLE !== 1'b1);
   end

   function automatic logic [24:0] xent(input int s, input logic [7:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
      case (s)
         0:       return {1'b1, 16'd0, op};
         1:       return {1'b1, 16'd1, a};
         2:       return {1'b1, 16'd2, b};
         3:       return {1'b0, 16'd0, 8'd0};
         default: return {1'b0, 16'd1, 8'd0};
      endcase
   endfunction

   task automatic issue(input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] b);
      @(negedge clk);
      check("cmd_ready_idle", o_cmd_ready, 1);
      i_cmd_valid = 1'b1;
      i_cmd_oper  = op;
      i_cmd_argA  = a;
      i_cmd_argB  = b;
      @(negedge clk);
      i_cmd_valid = 1'b0;
      i_cmd_oper  = 8'($urandom);
      i_cmd_argA  = 8'($urandom);
      i_cmd_argB  = 8'($urandom);
   endtask

   task automatic run_cmd(input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int lat, input int e,
                          input int h, input int hold,
                          input logic [7:0] m0, input logic [7:0] m1);
      int         n, ncomp, nexp;
      logic [7:0] er;
      logic [3:0] es;
      logic [1:0] ee;
      cfg_lat  = lat;
      cfg_err  = e;
      cfg_hang = h;
      mem0     = m0;
      mem1     = m1;
      cfg_base = xlog.size();
      ncomp = (e >= 0) ? e + 1 : (h >= 0) ? h : NSTEPS;
      nexp  = 1 + ncomp * (2 + lat) + ((h >= 0) ? 1 + TO : 0);
      ee    = (e >= 0) ? 2'b01 : (h >= 0) ? 2'b10 : 2'b00;
      er    = (ncomp >= 4) ? m0 : 8'h00;
      es    = (ncomp >= 5) ? m1[3:0] : 4'h0;
      issue(op, a, b);
      n = 1;
      while (!o_rsp_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, nexp);
      check("rsp_valid", o_rsp_valid, 1);
      check("result", o_rsp_result, er);
      check("status", o_rsp_status, es);
      check("err", o_rsp_err, ee);
      check("psel_resp", {o_PSEL, o_PENABLE, o_PWRITE}, 0);
      check("protocol", prot_errs, 0);
      check("nxfer", xlog.size() - cfg_base, ncomp);
      for (int i = 0; i < ncomp && cfg_base + i < xlog.size(); i++)
         check("xfer", xlog[cfg_base+i], xent(i, op, a, b));
      if (h >= 0) check("timeout_cycles", last_acc, TO);
      for (int k = 0; k < hold; k++) begin
         i_cmd_valid = 1'b1;
         i_cmd_oper  = 8'($urandom);
         @(negedge clk);
         check("hold_fields", {o_rsp_valid, o_rsp_result, o_rsp_status,
                               o_rsp_err}, {1'b1, er, es, ee});
         check("hold_cmd_ready", o_cmd_ready, 0);
      end
      i_cmd_valid = 1'b0;
      i_rsp_ready = 1'b1;
      @(negedge clk);
      i_rsp_ready = 1'b0;
      check("post_hs_valid", o_rsp_valid, 0);
      check("post_hs_ready", o_cmd_ready, 1);
   endtask

   initial begin
      int n;
      i_PRESET    = 1'b1;
      i_cmd_valid = 1'b0;
      i_cmd_oper  = '0;
      i_cmd_argA  = '0;
      i_cmd_argB  = '0;
      i_rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", o_cmd_ready, 1);
      check("rst_outs", {o_rsp_valid, o_PSEL, o_PENABLE, o_PWRITE,
                         o_PADDR, o_PWDATA}, 0);
      check("rst_rsp", {o_rsp_result, o_rsp_status, o_rsp_err}, 0);
      i_PRESET = 1'b0;

      run_cmd(8'h01, 8'h05, 8'h03, 1, -1, -1, 0, 8'h08, 8'h02);
      run_cmd(8'h11, 8'h22, 8'h33, 1, 1, -1, 0, 8'h5a, 8'h0f);
      run_cmd(8'h44, 8'h12, 8'h34, 1, -1, 3, 0, 8'h99, 8'h07);
      run_cmd(8'h0c, 8'hf0, 8'h0f, 1, -1, -1, 5, 8'hc3, 8'h0b);

      // reset while step 2 is in its ACCESS phase
      cfg_lat  = 3;
      cfg_err  = -1;
      cfg_hang = -1;
      cfg_base = xlog.size();
      issue(8'h21, 8'h43, 8'h65);
      n = 0;
      while (!(o_PENABLE && o_PADDR == 16'd2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rst_reach_step2", {o_PENABLE, o_PADDR}, {1'b1, 16'd2});
      i_PRESET = 1'b1;
      @(negedge clk);
      i_PRESET = 1'b0;
      check("midrst_apb", {o_PSEL, o_PENABLE}, 0);
      check("midrst_valid", o_rsp_valid, 0);
      check("midrst_ready", o_cmd_ready, 1);
      run_cmd(8'h77, 8'h88, 8'h99, 1, -1, -1, 0, 8'h3c, 8'h0e);

      for (int t = 0; t < 12; t++) begin
         int e, h;
         e = -1;
         h = -1;
         if ($urandom_range(0, 5) == 0) h = $urandom_range(0, NSTEPS - 1);
         else if ($urandom_range(0, 3) == 0) e = $urandom_range(0, 2);
         run_cmd(8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 3), e, h, $urandom_range(0, 3),
                 8'($urandom), 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
